// File: rtl/external_memory_responder.sv
// External memory responder: a word-addressed 32-bit memory behind a
// command/strobe handshake with programmable access latency and a shared data bus.
module external_memory_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ExternalDrive,
  input  logic [31:0] ExternalAddressBus,
  inout  wire  [31:0] ExternalDataBus,
  output logic        ExternalExchangeReady,
  output logic        AccessError
);

  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_FETCH = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b011;

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND, HOLD} state_t;

  state_t state, next_state;

  logic [31:0]          mem [DEPTH];
  logic [2:0]           cmd_q;
  logic [29:0]          addr_q;
  logic [3:0]           cnt;
  logic [31:0]          rdata;
  logic                 drive_bus;
  logic [ADDR_BITS-1:0] idx_q;
  logic                 oor_q;
  logic                 is_rd_q;
  logic                 is_wr_q;
  logic                 is_bad_q;
  logic                 accept;
  logic                 enter_resp;
  logic                 addr_lsb_unused;

  // byte-lane bits never select anything; the bus is word-addressed
  assign addr_lsb_unused = ^ExternalAddressBus[1:0];

  assign idx_q    = addr_q[ADDR_BITS-1:0];
  assign oor_q    = |addr_q[29:ADDR_BITS];
  assign is_rd_q  = (cmd_q == CMD_FETCH) || (cmd_q == CMD_READ);
  assign is_wr_q  = (cmd_q == CMD_WRITE);
  assign is_bad_q = cmd_q[2];

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (ExternalDrive != CMD_NOP) begin
          accept     = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        // a controller that drops or changes its command abandons the access
        if (ExternalDrive != cmd_q) begin
          next_state = IDLE;
        end else if (cnt == 4'd0) begin
          enter_resp = 1'b1;
          next_state = RESPOND;
        end
      end
      RESPOND: next_state = HOLD;
      HOLD: begin
        if (ExternalDrive != cmd_q) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      cnt         <= '0;
      rdata       <= '0;
      AccessError <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        cmd_q  <= ExternalDrive;
        addr_q <= ExternalAddressBus[31:2];
        cnt    <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && next_state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rdata <= (is_rd_q && !oor_q) ? mem[idx_q] : 32'h0000_0000;
        if (oor_q || is_bad_q) AccessError <= 1'b1;
      end
    end
  end

  // storage is deliberately outside reset so contents survive it
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && is_wr_q && !oor_q) mem[idx_q] <= ExternalDataBus;
  end

  assign drive_bus             = (state == RESPOND || state == HOLD) && !is_wr_q;
  assign ExternalDataBus       = drive_bus ? rdata : 32'hzzzz_zzzz;
  assign ExternalExchangeReady = (state == RESPOND);

endmodule

// File: doc/external_memory_responder.md
EXTERNAL_MEMORY_RESPONDER -- requirements
Module: external_memory_responder

Interface
REQ-001 Parameter ADDR_BITS, default 8: word-index width; memory depth is 2^ADDR_BITS 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2: added access latency in clocks, legal range 0..15.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 ExternalDrive  input  3: command from the memory controller; 000 NOP, 001 instruction fetch, 010 memory read, 011 memory write, 100/101 IO read/write, 110/111 reserved.
REQ-006 ExternalAddressBus  input  32: byte address; bits [1:0] ignored; word index = bits [ADDR_BITS+1:2].
REQ-007 ExternalDataBus  inout  32: read data out (driven by this block) or write data in (driven by the controller).
REQ-008 ExternalExchangeReady  output  1: one-cycle completion strobe to the controller.
REQ-009 AccessError  output  1: sticky flag, set on out-of-range, IO or reserved commands.

Function
REQ-010 FSM states SHALL be IDLE, WAIT, RESPOND and HOLD.
REQ-011 IDLE: on an edge with ExternalDrive != 000, SHALL latch the command and address, load the wait counter with WAIT_CYCLES, and go to WAIT.
REQ-012 WAIT: counter == 0 at an edge -> RESPOND; otherwise decrement the counter.
REQ-013 Latency: ExternalExchangeReady SHALL be high in exactly the cycle after edge k+WAIT_CYCLES+1, where k is the accepting edge.
REQ-014 WAIT abort: latched command != current ExternalDrive at any WAIT edge -> IDLE, no Ready, no memory write.
REQ-015 RESPOND lasts one cycle with Ready=1; the next edge goes to HOLD (Ready=0).
REQ-016 Reads (001, 010): read data SHALL be registered on entry to RESPOND and driven on ExternalDataBus during RESPOND and HOLD.
REQ-017 Writes (011): on the edge entering RESPOND, ExternalDataBus SHALL be written to mem[index]; the bus is never driven by this block during a write.
REQ-018 ExternalDataBus SHALL be high-Z in every state and command other than REQ-016.
REQ-019 HOLD -> IDLE on the first edge where ExternalDrive != the latched command.
REQ-020 A new command is never accepted in the same edge as HOLD -> IDLE; the earliest acceptance is the following edge.
REQ-021 Out of range: address bits [31:ADDR_BITS+2] nonzero -> reads return 32'h0000_0000, writes are discarded, Ready is still pulsed, AccessError is set.
REQ-022 IO/reserved commands (100-111) SHALL complete as a read of 32'h0 with the bus driven, Ready pulsed, and AccessError set.
REQ-023 Fetch and data read SHALL be identical apart from the latched command.
REQ-024 No other path sets or clears AccessError, except reset.

Reset
REQ-025 rst=1 at an edge: state=IDLE, ExternalExchangeReady=0, AccessError=0, counter=0, read register=0, ExternalDataBus released; this applies regardless of state.
REQ-026 A write pending in WAIT when reset arrives SHALL NOT be committed.
REQ-027 Memory array contents SHALL NOT be cleared by reset.
REQ-028 The first command SHALL be accepted on the first edge with rst=0 and ExternalDrive != 000.

Verification
REQ-029 Cmd 011, addr 0x0000_0010, data 0xCAFE_F00D, held until Ready; then cmd 010 at the same addr -> Ready 3 cycles after acceptance (WAIT_CYCLES=2), bus = 0xCAFE_F00D during RESPOND and HOLD.
REQ-030 Cmd 001 at 0x0000_0013 after the above -> returns word index 4 = 0xCAFE_F00D; bits [1:0] ignored.
REQ-031 Cmd 010 at 0x0001_0000 -> data 0x0, Ready pulsed, AccessError=1 and remains 1 after later good accesses until rst.
REQ-032 Cmd 011 then ExternalDrive -> 000 during WAIT -> no Ready; a later read of that addr returns the old value.
REQ-033 rst asserted in HOLD of a read -> next cycle bus high-Z, Ready=0, state IDLE; memory contents intact on re-read.
REQ-034 WAIT_CYCLES=0 build: read accepted at edge k -> Ready high in the cycle after edge k+1, single cycle only.
